// File: rtl/i2s_adc_rx.sv
// i2s_adc_rx: I2S receiver for the codec ADC path.
// Oversamples BCLK/ADCLRC/ADCDAT in the clk domain, deserialises MSB-first
// words and emits one left/right sample pair per LRC frame.
// Ports:
//   clk, reset_n        system clock (>= 4x BCLK), async active-low reset
//   enable              capture enable (codec configuration done)
//   bclk/adclrc/adcdat  raw codec I2S pins, asynchronous to clk
//   sample_l/sample_r   last complete frame, two's complement
//   valid               1-clk pulse when sample_l/sample_r update
//   frame_err           sticky short-slot flag, cleared while enable=0
module i2s_adc_rx #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              bclk,
  input  logic              adclrc,
  input  logic              adcdat,
  output logic [DATA_W-1:0] sample_l,
  output logic [DATA_W-1:0] sample_r,
  output logic              valid,
  output logic              frame_err
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, SYNC, LEFT, RIGHT} state_t;

  state_t            state;
  logic              bclk_s1, bclk_s2, bclk_s3;
  logic              lrc_s1, lrc_s2, dat_s1, dat_s2;
  logic              lrc_prev;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shift;
  logic [DATA_W-1:0] left_buf;
  logic              left_ok, right_ok;

  logic              bclk_rise_c, boundary_c, bit_done_c;
  logic [DATA_W-1:0] word_c;

  // Two-flop synchronisers; bclk gets a third flop for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bclk_s1 <= 1'b0;
      bclk_s2 <= 1'b0;
      bclk_s3 <= 1'b0;
      lrc_s1  <= 1'b0;
      lrc_s2  <= 1'b0;
      dat_s1  <= 1'b0;
      dat_s2  <= 1'b0;
    end else begin
      bclk_s1 <= bclk;
      bclk_s2 <= bclk_s1;
      bclk_s3 <= bclk_s2;
      lrc_s1  <= adclrc;
      lrc_s2  <= lrc_s1;
      dat_s1  <= adcdat;
      dat_s2  <= dat_s1;
    end
  end

  assign bclk_rise_c = bclk_s2 & ~bclk_s3;
  // The LRC edge is the I2S one-bit-delay point; its dat bit is never captured.
  assign boundary_c  = bclk_rise_c & (lrc_s2 != lrc_prev);
  assign bit_done_c  = bclk_rise_c & ~boundary_c & (bit_cnt == CNT_W'(DATA_W - 1));
  assign word_c      = {shift[DATA_W-2:0], dat_s2};

  // Slot deserialiser: restarts on every boundary, saturates after DATA_W bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lrc_prev <= 1'b0;
      bit_cnt  <= '0;
      shift    <= '0;
    end else if (bclk_rise_c) begin
      lrc_prev <= lrc_s2;
      if (boundary_c) begin
        bit_cnt <= '0;
        shift   <= '0;
      end else if (bit_cnt < CNT_W'(DATA_W)) begin
        bit_cnt <= bit_cnt + CNT_W'(1);
        shift   <= word_c;
      end
    end
  end

  // Frame FSM; valid only fires for a frame whose left and right words are both full.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      sample_l  <= '0;
      sample_r  <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      left_buf  <= '0;
      left_ok   <= 1'b0;
      right_ok  <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (!enable) begin
        state     <= IDLE;
        left_ok   <= 1'b0;
        right_ok  <= 1'b0;
        frame_err <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= SYNC;
          SYNC: begin
            if (boundary_c && !lrc_s2) begin
              state   <= LEFT;
              left_ok <= 1'b0;
            end
          end
          LEFT: begin
            if (bit_done_c) begin
              left_buf <= word_c;
              left_ok  <= 1'b1;
            end
            if (boundary_c && lrc_s2) begin
              state    <= RIGHT;
              right_ok <= 1'b0;
              if (!left_ok) frame_err <= 1'b1;
            end
          end
          RIGHT: begin
            if (bit_done_c) begin
              right_ok <= 1'b1;
              if (left_ok) begin
                sample_l <= left_buf;
                sample_r <= word_c;
                valid    <= 1'b1;
              end
            end
            if (boundary_c && !lrc_s2) begin
              state   <= LEFT;
              left_ok <= 1'b0;
              if (!right_ok) frame_err <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2s_adc_rx.sv
// tb_i2s_adc_rx: directed bench for i2s_adc_rx. Stimulus pushes expected
// sample pairs into a queue; a negedge monitor pops and compares on valid,
// and also checks pulse width and BCLK-to-valid latency.
module tb_i2s_adc_rx;

  localparam int unsigned DATA_W = 16;

  typedef struct packed {
    logic [DATA_W-1:0] l;
    logic [DATA_W-1:0] r;
  } pair_t;

  logic              clk = 1'b0;
  logic              reset_n, enable, bclk, adclrc, adcdat;
  logic [DATA_W-1:0] sample_l, sample_r;
  logic              valid, frame_err;

  int    n_tests = 0;
  int    n_fail  = 0;
  pair_t exp_q[$];
  time   r_rise  = 0;
  logic  prev_valid = 1'b0;

  i2s_adc_rx #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .bclk      (bclk),
    .adclrc    (adclrc),
    .adcdat    (adcdat),
    .sample_l  (sample_l),
    .sample_r  (sample_r),
    .valid     (valid),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every valid must match the oldest queued pair and arrive 3 clk after the last R-bit rise.
  always @(negedge clk) begin
    if (valid) begin
      check("valid_width", {31'd0, prev_valid}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        pair_t e;
        e = exp_q.pop_front();
        check("sample_l", 32'(sample_l), 32'(e.l));
        check("sample_r", 32'(sample_r), 32'(e.r));
        check("latency_ns", 32'($time - r_rise), 32'd30);
      end
    end
    prev_valid = valid;
  end

  // One BCLK period = 8 clk; lrc/dat change on the falling edge.
  task automatic bclk_cycle(input logic lrc_v, input logic dat_v, input logic mark, input logic do_rst);
    bclk   = 1'b0;
    adclrc = lrc_v;
    adcdat = dat_v;
    repeat (4) @(negedge clk);
    bclk = 1'b1;
    if (mark) r_rise = $time;
    if (do_rst) begin
      #2 reset_n = 1'b0;
      #2;
      check("rst_sample_l", 32'(sample_l), 32'd0);
      check("rst_sample_r", 32'(sample_r), 32'd0);
      check("rst_valid", {31'd0, valid}, 32'd0);
      check("rst_frame_err", {31'd0, frame_err}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
    end else begin
      repeat (4) @(negedge clk);
    end
  endtask

  // Edge 0 carries the LRC change (delay bit), then nbits data bits MSB first, then padding.
  task automatic send_slot(input logic ch, input logic [DATA_W-1:0] w, input int nbits,
                           input int edges, input int en_at, input int rst_at);
    for (int e = 0; e < edges; e++) begin
      logic d;
      if (e >= 1 && e <= nbits) d = w[DATA_W-e];
      else d = 1'($urandom());
      if (e == en_at) enable = 1'b1;
      bclk_cycle(ch, d, ch && (e == DATA_W) && (nbits >= DATA_W), e == rst_at);
    end
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r,
                            input int edges, input logic expect_valid);
    pair_t p;
    p.l = l;
    p.r = r;
    if (expect_valid) exp_q.push_back(p);
    send_slot(1'b0, l, DATA_W, edges, -1, -1);
    send_slot(1'b1, r, DATA_W, edges, -1, -1);
  endtask

  initial begin
    reset_n = 1'b0;
    enable  = 1'b0;
    bclk    = 1'b0;
    adclrc  = 1'b0;
    adcdat  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_sample_l", 32'(sample_l), 32'd0);
    check("reset_sample_r", 32'(sample_r), 32'd0);
    check("reset_valid", {31'd0, valid}, 32'd0);
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Basic frames after enable; a leading right slot gives the first left boundary.
    enable = 1'b1;
    send_slot(1'b1, 16'h0000, DATA_W, 32, -1, -1);
    send_frame(16'hA5C3, 16'h1234, 32, 1'b1);
    send_frame(16'hA5C3, 16'h1234, 32, 1'b1);
    check("t1_frame_err", {31'd0, frame_err}, 32'd0);

    // Sign and bit-order extremes.
    send_frame(16'h8000, 16'h7FFF, 32, 1'b1);
    send_frame(16'hFFFF, 16'h0001, 32, 1'b1);

    // Disabled: outputs hold; enable raised mid right slot drops that frame.
    enable = 1'b0;
    repeat (2) @(negedge clk);
    check("hold_sample_l", 32'(sample_l), 32'h0000FFFF);
    check("hold_sample_r", 32'(sample_r), 32'h00000001);
    send_slot(1'b0, 16'h1111, DATA_W, 32, -1, -1);
    send_slot(1'b1, 16'h2222, DATA_W, 32, 10, -1);
    send_frame(16'h0F0F, 16'hF0F0, 32, 1'b1);

    // Short left slot: 12 BCLKs = delay bit + 11 data bits.
    send_slot(1'b0, 16'hDEAD, 11, 12, -1, -1);
    send_slot(1'b1, 16'hBEEF, DATA_W, 32, -1, -1);
    check("short_frame_err", {31'd0, frame_err}, 32'd1);
    send_frame(16'h1357, 16'h2468, 32, 1'b1);
    check("sticky_frame_err", {31'd0, frame_err}, 32'd1);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    check("clear_frame_err", {31'd0, frame_err}, 32'd0);
    enable = 1'b1;

    // Minimum legal slot: delay bit + 16 data bits, no padding, back-to-back.
    send_frame(16'h0001, 16'h8000, 17, 1'b1);
    send_frame(16'h7FFF, 16'hFFFE, 17, 1'b1);
    send_frame(16'hAAAA, 16'h5555, 17, 1'b1);
    send_frame(16'hC001, 16'h3FFC, 17, 1'b1);
    check("tight_frame_err", {31'd0, frame_err}, 32'd0);

    // Reset pulse during right-slot bit 8; resync on the next left boundary.
    send_slot(1'b0, 16'h3C3C, DATA_W, 32, -1, -1);
    send_slot(1'b1, 16'h5A5A, DATA_W, 32, -1, 8);
    send_frame(16'h0BAD, 16'hF00D, 32, 1'b1);
    check("post_rst_frame_err", {31'd0, frame_err}, 32'd0);

    repeat (20) @(negedge clk);
    check("pending_expected", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
